// File: rtl/fifo_pack_pkg.sv
// Shared types and width helpers for the FIFO read-side word packer.
package fifo_pack_pkg;

   typedef enum logic {
      FILL = 1'b0,
      OUT  = 1'b1
   } pack_state_t;

   function automatic int unsigned count_width(input int unsigned bytes_per_word);
      return $clog2(bytes_per_word) + 1;
   endfunction

   function automatic int unsigned word_width(input int unsigned data_width,
                                              input int unsigned bytes_per_word);
      return data_width * bytes_per_word;
   endfunction

   localparam int unsigned DEF_DATA_WIDTH     = 8;
   localparam int unsigned DEF_BYTES_PER_WORD = 4;
   localparam int unsigned DEF_COUNT_WIDTH    = count_width(DEF_BYTES_PER_WORD);
   localparam int unsigned DEF_WORD_WIDTH     = word_width(DEF_DATA_WIDTH, DEF_BYTES_PER_WORD);

endpackage

// File: rtl/fifo_idle_timer.sv
// Saturating idle counter with terminal-count flag; LIMIT of 0 disables it.
module fifo_idle_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   generate
      if (LIMIT == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk, rst, clr, en};
         assign done = 1'b0;
      end else begin : g_on
         localparam int unsigned W = $clog2(LIMIT + 1);
         localparam logic [W-1:0] TERM = W'(LIMIT);

         logic [W-1:0] cnt;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               cnt <= '0;
            end else if (en && (cnt != TERM)) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign done = (cnt == TERM);
      end
   endgenerate

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from a FIFO read port and packs them little-endian into words
// presented on a valid/ready output, with flush and idle-timeout emission.
module fifo_word_packer
   import fifo_pack_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned BYTES_PER_WORD = 4,
   parameter int unsigned FLUSH_TIMEOUT  = 16
) (
   input  logic                                   rd_clk,
   input  logic                                   rst,
   input  logic                                   fifo_empty,
   output logic                                   fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]                  fifo_data,
   input  logic                                   flush,
   output logic [DATA_WIDTH*BYTES_PER_WORD-1:0]   word_out,
   output logic [$clog2(BYTES_PER_WORD):0]        word_bytes,
   output logic                                   word_valid,
   input  logic                                   word_ready
);

   localparam int unsigned CW = count_width(BYTES_PER_WORD);
   localparam int unsigned WW = word_width(DATA_WIDTH, BYTES_PER_WORD);
   localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

   pack_state_t     state_q, state_d;
   logic [CW-1:0]   count;
   logic [CW-1:0]   cnt_nxt;
   logic [WW-1:0]   lanes;
   logic            pending;
   logic            flush_hold;
   logic            flush_req;
   logic            idle_done;
   logic            timeout_go;
   logic            go_out;
   logic            handshake;

   assign cnt_nxt    = count + CW'(pending);
   assign flush_req  = flush || flush_hold;
   assign timeout_go = idle_done && (count != '0) && !pending;
   assign handshake  = (state_q == OUT) && word_ready;

   // Pops stop once a flush is held or the timeout fires, so no byte can
   // land after the decision to emit has been made.
   always_comb begin
      fifo_rd_en = 1'b0;
      word_valid = 1'b0;
      if (state_q == FILL) begin
         fifo_rd_en = !rst && !fifo_empty && ((count + CW'(pending)) < FULL)
                      && !flush_hold && !timeout_go;
      end else begin
         word_valid = 1'b1;
      end
   end

   always_comb begin
      go_out  = 1'b0;
      state_d = state_q;
      case (state_q)
         FILL: begin
            go_out = (cnt_nxt == FULL)
                     || (flush_req && !fifo_rd_en && (cnt_nxt != '0))
                     || timeout_go;
            if (go_out) state_d = OUT;
         end
         OUT: begin
            if (word_ready) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         pending    <= 1'b0;
         flush_hold <= 1'b0;
         count      <= '0;
         lanes      <= '0;
      end else begin
         pending    <= fifo_rd_en;
         // A flush that coincides with a pop in flight waits for that byte.
         flush_hold <= (state_q == FILL) && !go_out && flush_req && fifo_rd_en;
         if (pending) begin
            count <= cnt_nxt;
            for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
               if (count == CW'(i)) lanes[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
            end
         end
         if (handshake) begin
            count <= '0;
            lanes <= '0;
         end
      end
   end

   fifo_idle_timer #(
      .LIMIT(FLUSH_TIMEOUT)
   ) u_idle_timer (
      .clk (rd_clk),
      .rst (rst),
      .clr (pending || go_out),
      .en  ((state_q == FILL) && (count != '0) && !pending),
      .done(idle_done)
   );

   assign word_out   = lanes;
   assign word_bytes = count;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer driven by a behavioural FIFO read port.
module tb_fifo_word_packer;

   logic        rd_clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_data;
   logic        flush;
   logic [31:0] word_out;
   logic [2:0]  word_bytes;
   logic        word_valid;
   logic        word_ready;

   logic [7:0]  mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        force_empty = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          viol = 0;

   always #5 rd_clk = ~rd_clk;

   assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;

   always @(posedge rd_clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_data <= mem[rd_ptr[7:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   always @(negedge rd_clk) begin
      if (fifo_rd_en && fifo_empty) viol++;
   end

   fifo_word_packer #(
      .DATA_WIDTH(8),
      .BYTES_PER_WORD(4),
      .FLUSH_TIMEOUT(16)
   ) dut (
      .rd_clk    (rd_clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .fifo_data (fifo_data),
      .flush     (flush),
      .word_out  (word_out),
      .word_bytes(word_bytes),
      .word_valid(word_valid),
      .word_ready(word_ready)
   );

   typedef struct {
      logic [7:0]  b [4];
      int          n;
      logic [31:0] word;
      logic [2:0]  nbytes;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge rd_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = -1;
      for (int i = 0; i < limit; i++) begin
         if (word_valid) begin
            n = i;
            return;
         end
         cyc();
      end
   endtask

   task automatic wait_drain(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (rd_ptr == wr_ptr) return;
         cyc();
      end
      chk("drain_timeout", 32'(wr_ptr - rd_ptr), 32'd0);
   endtask

   initial begin
      int          n;
      int          first;
      int          vt;
      logic [31:0] held;
      logic [31:0] got [2];
      int          ngot;

      vecs[0].b = '{8'h01, 8'h02, 8'h03, 8'h04}; vecs[0].n = 4; vecs[0].word = 32'h04030201; vecs[0].nbytes = 3'd4;
      vecs[1].b = '{8'hFF, 8'h00, 8'hA5, 8'h5A}; vecs[1].n = 4; vecs[1].word = 32'h5AA500FF; vecs[1].nbytes = 3'd4;
      vecs[2].b = '{8'h10, 8'h20, 8'h30, 8'h00}; vecs[2].n = 3; vecs[2].word = 32'h00302010; vecs[2].nbytes = 3'd3;
      vecs[3].b = '{8'h7E, 8'h00, 8'h00, 8'h00}; vecs[3].n = 1; vecs[3].word = 32'h0000007E; vecs[3].nbytes = 3'd1;
      vecs[4].b = '{8'hC3, 8'h3C, 8'h00, 8'h00}; vecs[4].n = 2; vecs[4].word = 32'h00003CC3; vecs[4].nbytes = 3'd2;

      rst = 1'b1; flush = 1'b0; word_ready = 1'b1;
      cyc(); cyc();
      chk("reset_valid", 32'(word_valid), 32'd0);
      chk("reset_word", word_out, 32'd0);
      chk("reset_bytes", 32'(word_bytes), 32'd0);
      chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      rst = 1'b0;
      cyc();

      // table-driven words: full words stream out, partial words via flush
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < vecs[v].n; k++) push(vecs[v].b[k]);
         if (vecs[v].n < 4) begin
            #1;
            wait_drain(20);
            cyc(); cyc();
            flush = 1'b1;
            cyc();
            flush = 1'b0;
         end
         #1;
         wait_valid(20, n);
         chk($sformatf("vec%0d_seen", v), 32'(n >= 0), 32'd1);
         chk($sformatf("vec%0d_word", v), word_out, vecs[v].word);
         chk($sformatf("vec%0d_bytes", v), 32'(word_bytes), 32'(vecs[v].nbytes));
         cyc();
         chk($sformatf("vec%0d_valid_drop", v), 32'(word_valid), 32'd0);
      end

      // full-word latency from the first pop
      cyc();
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      #1;
      first = -1; vt = -1;
      for (int i = 0; i < 20 && vt < 0; i++) begin
         if (fifo_rd_en && first < 0) first = i;
         if (word_valid) vt = i;
         else cyc();
      end
      chk("lat_first_pop", 32'(first), 32'd0);
      chk("lat_valid", 32'(vt), 32'd5);
      chk("lat_word", word_out, 32'h04030201);
      chk("lat_bytes", 32'(word_bytes), 32'd4);
      cyc();
      chk("lat_one_cycle", 32'(word_valid), 32'd0);

      // backpressure holds the word and leaves the fifth byte in the FIFO
      cyc();
      word_ready = 1'b0;
      push(8'h41); push(8'h42); push(8'h43); push(8'h44); push(8'h45);
      #1;
      wait_valid(20, n);
      chk("bp_seen", 32'(n >= 0), 32'd1);
      held = word_out;
      chk("bp_word", held, 32'h44434241);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("bp_stable", word_out, held);
         chk("bp_valid", 32'(word_valid), 32'd1);
         chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
      end
      chk("bp_left", 32'(wr_ptr - rd_ptr), 32'd1);
      word_ready = 1'b1;
      cyc();
      chk("bp_release", 32'(word_valid), 32'd0);
      wait_valid(40, n);
      chk("bp_next_word", word_out, 32'h00000045);
      chk("bp_next_bytes", 32'(word_bytes), 32'd1);
      cyc();

      // idle timeout emits a two-byte partial word
      cyc();
      push(8'h0A); push(8'h0B);
      #1;
      vt = -1;
      for (int i = 0; i < 40 && vt < 0; i++) begin
         if (word_valid) vt = i;
         else cyc();
      end
      chk("to_latency", 32'(vt), 32'd20);
      chk("to_word", word_out, 32'h00000B0A);
      chk("to_bytes", 32'(word_bytes), 32'd2);
      cyc();

      // flush in the cycle of the pop is deferred until the byte lands
      cyc();
      push(8'h11);
      flush = 1'b1;
      #1;
      chk("fl_pop_now", 32'(fifo_rd_en), 32'd1);
      cyc();
      flush = 1'b0;
      #1;
      wait_valid(10, n);
      chk("fl_latency", 32'(n), 32'd1);
      chk("fl_word", word_out, 32'h00000011);
      chk("fl_bytes", 32'(word_bytes), 32'd1);
      cyc();
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      vt = 0;
      for (int i = 0; i < 6; i++) begin
         if (word_valid) vt++;
         cyc();
      end
      chk("fl_empty_ignored", 32'(vt), 32'd0);

      // empty flag toggling during an 8-byte burst
      for (int k = 0; k < 8; k++) push(8'h51 + 8'(k));
      ngot = 0;
      for (int i = 0; i < 80 && ngot < 2; i++) begin
         force_empty = ~force_empty;
         #1;
         if (word_valid) begin
            got[ngot] = word_out;
            chk("tg_bytes", 32'(word_bytes), 32'd4);
            ngot++;
         end
         cyc();
      end
      force_empty = 1'b0;
      chk("tg_count", 32'(ngot), 32'd2);
      chk("tg_word0", got[0], 32'h54535251);
      chk("tg_word1", got[1], 32'h58575655);
      chk("tg_drained", 32'(wr_ptr - rd_ptr), 32'd0);

      // reset in the middle of a word
      cyc();
      push(8'h21); push(8'h22);
      cyc(); cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("rm_valid", 32'(word_valid), 32'd0);
      chk("rm_word", word_out, 32'd0);
      chk("rm_bytes", 32'(word_bytes), 32'd0);
      push(8'h31); push(8'h32); push(8'h33); push(8'h34);
      #1;
      wait_valid(20, n);
      chk("rm_seen", 32'(n >= 0), 32'd1);
      chk("rm_next_word", word_out, 32'h34333231);
      chk("rm_next_bytes", 32'(word_bytes), 32'd4);
      cyc();

      chk("rd_en_while_empty", 32'(viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Read-side consumer of dual_clock_fifo, running in the rd_clk domain.
- Pops bytes from the FIFO read port and packs them little-endian into BYTES_PER_WORD-byte words.
- Presents each word on a valid/ready output.
- Emits partial words on an explicit flush request or after an idle timeout, so trailing bytes are never stranded.

Parameters:
- DATA_WIDTH, 8: FIFO byte width; matches the dual_clock_fifo data_out width.
- BYTES_PER_WORD, 4: bytes packed per output word; must be >= 2.
- FLUSH_TIMEOUT, 16: idle rd_clk cycles with a partial word before an automatic flush; 0 disables the timeout.

Ports:
- rd_clk  in  1  clock; the FIFO read clock.
- rst  in  1  reset.
- fifo_empty  in  1  empty flag from the FIFO.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_data  in  DATA_WIDTH  FIFO data_out.
- flush  in  1  single-cycle request to emit the partial word.
- word_out  out  DATA_WIDTH*BYTES_PER_WORD  packed word; byte 0 sits in the LSBs.
- word_bytes  out  $clog2(BYTES_PER_WORD)+1  count of valid bytes, 1..BYTES_PER_WORD.
- word_valid  out  1  word_out/word_bytes valid.
- word_ready  in  1  downstream accepts the word.

Interface (already decided):
- One clock, rd_clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset: while rst is sampled high, all of the following clear: fifo_rd_en=0, word_valid=0, word_out=0, word_bytes=0, byte count=0, pending=0, idle counter=0, state=FILL.
- Reset mid-operation: a byte whose pop was issued the cycle before reset is discarded, and any partial word is lost. This loss is accepted behaviour.
- FIFO read timing:
  - fifo_data is valid the cycle after fifo_rd_en is high with fifo_empty low.
  - A 1-bit pending flag tracks a pop in flight.
- States: FILL and OUT.
- FILL state:
  - fifo_rd_en = !fifo_empty && (count + pending < BYTES_PER_WORD). This is combinational from fifo_empty and registered state.
  - When pending is set, fifo_data is written into lane [count] and count increments.
  - Back-to-back pops are allowed, giving one byte per cycle.
- Full-word latency: with fifo_rd_en high in cycles 0..3, bytes are captured at the end of cycles 1..4 and word_valid rises in cycle 5 with word_bytes=4.
- FILL -> OUT, on any of:
  - count reaches BYTES_PER_WORD;
  - flush with count>0 and pending=0;
  - idle counter == FLUSH_TIMEOUT with count>0 and pending=0.
- Flush while a pop is pending: the flush is held and taken once the pending byte lands. If that byte completes the word, the flush merges into the full-word emit.
- Flush with count=0 and pending=0: ignored, no output.
- Partial words: unused lanes of word_out are zero, and word_bytes = count.
- Idle counter:
  - Increments each FILL cycle in which count>0 and no byte is captured.
  - Clears on any capture and on entering OUT.
  - Saturates at FLUSH_TIMEOUT.
- OUT state:
  - word_valid=1 and fifo_rd_en=0.
  - word_out and word_bytes stay stable until word_ready.
  - When word_valid && word_ready: return to FILL with count=0. word_valid is 0 the next cycle, and pops may resume that same next cycle.
- word_ready asserted while word_valid=0 has no effect.

Decomposition:
- Package fifo_pack_pkg holds:
  - state enum {FILL, OUT};
  - localparams for the count width and word width derived from the parameters.
- One sub-module, fifo_idle_timer: a saturating counter with clear/enable inputs and a terminal-count output. Instantiated once; parameter 0 disables it.
- Lane write and the FSM stay in the top level.

Test Plan:
- Full word: FIFO holds 01,02,03,04 and word_ready=1 -> word_out=32'h04030201, word_bytes=4, word_valid high for one cycle, 5 cycles after the first fifo_rd_en.
- Backpressure: hold word_ready=0 for 10 cycles after word_valid -> word_out stable, fifo_rd_en=0 throughout, 5th byte 05 stays in the FIFO. Release -> 05 lands in the next word at lane 0.
- Timeout flush: push 0A,0B then nothing, FLUSH_TIMEOUT=16 -> 16 idle cycles after the 0B capture, word_out=32'h00000B0A with word_bytes=2.
- Explicit flush: push 11, pulse flush the cycle of its pop -> flush is deferred until capture, then word_out=32'h00000011, word_bytes=1. Flush with an empty packer -> no word_valid.
- Empty/full edges: empty toggles every other cycle during an 8-byte burst -> two words 32'h..., no duplicated or dropped bytes, and fifo_rd_en never high while fifo_empty=1.
- Reset mid-word: assert rst after 2 bytes captured -> word_valid=0, word_out=0 next cycle. The next 4 bytes form a clean word with word_bytes=4.
